melody_sequencer: RTL and testbench
===================================

MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 SHALL have parameter BEAT_CYCLES, default 25_000_000, clk cycles per beat.
REQ-002 SHALL have parameter GAP_CYCLES, default 2_500_000, silent tail per note (NOTE_GAP_EN only); GAP_CYCLES < BEAT_CYCLES.
REQ-003 clk  in  1  system clock, 100 MHz.
REQ-004 rst  in  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 play  in  1  start from IDLE, or resume from PAUSE.
REQ-006 pause  in  1  pause playback.
REQ-007 stop  in  1  abort to IDLE.
REQ-008 loop  in  1  restart at entry 0 on song end.
REQ-009 wr_en  in  1  song-RAM write strobe.
REQ-010 wr_addr  in  4  song-RAM entry index.
REQ-011 wr_data  in  6  entry {note[5:2], beats[1:0]}.
REQ-012 pitch  out  22  half-period count to the note generator.
REQ-013 music  out  1  tone enable to the note generator.
REQ-014 gen_start  out  1  high in PLAY and PAUSE; enables the note generator.
REQ-015 note_idx  out  4  current entry index.
REQ-016 busy  out  1  high when state != IDLE.
REQ-017 done  out  1  one-cycle pulse on natural song end.

Function
REQ-018 SHALL hold a 16x6 song RAM; write when wr_en=1 and state=IDLE, ignored otherwise.
REQ-019 SHALL decode note: 0 rest; 1..8 = C4,D4,E4,F4,G4,A4,B4,C5 with pitch 191109,170264,151684,143171,127550,113635,101238,95556; 9..14 rest; 15 END.
REQ-020 Rest entries SHALL drive music=0, pitch=0.
REQ-021 Note duration SHALL be (beats+1)*BEAT_CYCLES cycles.
REQ-022 SHALL implement states IDLE, PLAY, PAUSE; priority stop > pause > play when simultaneous.
REQ-023 IDLE->PLAY on play=1: note_idx=0, beat and duration counters cleared.
REQ-024 PLAY->PAUSE on pause=1: counters frozen, music=0, pitch held; PAUSE->PLAY on play=1 and pause=0, resuming the same count.
REQ-025 Any state->IDLE on stop=1: counters and note_idx cleared, done not pulsed.
REQ-026 Duration expiry SHALL advance note_idx by 1; 15 wraps to 0 and is treated as END.
REQ-027 END reached: loop=1 SHALL restart at entry 0 with no idle cycle; loop=0 SHALL go to IDLE and pulse done.
REQ-028 END at entry 0 SHALL go to IDLE and pulse done regardless of loop.
REQ-029 pitch and music SHALL be registered, reflecting entry[note_idx] and state with one-cycle latency.
REQ-030 Write to the entry currently playing is impossible (IDLE-only writes); no hazard.

Reset
REQ-031 rst=1 SHALL force state IDLE, note_idx=0, counters=0, pitch=0, music=0, gen_start=0, busy=0, done=0.
REQ-032 rst SHALL load every RAM entry with 6'b111100 (END).
REQ-033 rst mid-playback SHALL abort immediately with no done pulse.

Configuration
REQ-034 With NOTE_GAP_EN defined, music SHALL be 0 during the last GAP_CYCLES cycles of each note (pitch unchanged).
REQ-035 Without NOTE_GAP_EN, music SHALL stay high for the full note duration; GAP_CYCLES unused.

Verification (BEAT_CYCLES=4, GAP_CYCLES=1)
REQ-036 Reset, play with RAM untouched -> one cycle PLAY, then IDLE, done pulses once, music stays 0.
REQ-037 RAM {0:note1 beats0, 1:note5 beats1, 2:END}, play -> pitch 191109 for 4 cycles, 127550 for 8 cycles, then done, busy=0.
REQ-038 Same song, loop=1 -> pitch returns to 191109 right after entry 1, no done pulse.
REQ-039 Pause at cycle 2 of entry 0 for 10 cycles, then play -> music 0 while paused, entry 0 finishes 2 cycles after resume.
REQ-040 stop and play asserted together mid-song -> IDLE, note_idx=0, no done; wr_en during PLAY -> RAM unchanged.
REQ-041 NOTE_GAP_EN defined, entry note3 beats0 -> music high 3 cycles, low 1, pitch 151684 held for all 4.

Source files
------------

// File: rtl/melody_sequencer.sv
// melody_sequencer: plays a 16-entry song RAM as a sequence of notes.
//
// Each RAM entry is {note[3:0], beats[1:0]}. A note lasts (beats+1)*BEAT_CYCLES
// clocks. Note 0 and notes 9..14 are rests, notes 1..8 are C4..C5, and note 15
// marks the song end. The song RAM can only be written while IDLE.
//
// Optional feature macro: NOTE_GAP_EN. When it is defined, music drops for the
// last GAP_CYCLES clocks of every note so that repeated notes are audibly
// separated; pitch is unchanged during that gap.
//
// Ports:
//   clk        system clock (100 MHz)
//   rst        asynchronous active-high reset; RAM reloads with END entries
//   play       start from IDLE, or resume from PAUSE
//   pause      pause playback
//   stop       abort to IDLE (highest priority)
//   loop       restart at entry 0 when the song ends
//   wr_en      song-RAM write strobe (IDLE only)
//   wr_addr    song-RAM entry index
//   wr_data    song-RAM entry {note, beats}
//   pitch      half-period count for the note generator (registered)
//   music      tone enable for the note generator (registered)
//   gen_start  high in PLAY and PAUSE
//   note_idx   current entry index
//   busy       high when not IDLE
//   done       one-cycle pulse on natural song end
module melody_sequencer #(
  parameter int unsigned BEAT_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 2_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        play,
  input  logic        pause,
  input  logic        stop,
  input  logic        loop,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [5:0]  wr_data,
  output logic [21:0] pitch,
  output logic        music,
  output logic        gen_start,
  output logic [3:0]  note_idx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CNT_W     = $clog2(BEAT_CYCLES + 1);
  localparam logic [3:0]  NOTE_END  = 4'd15;
  localparam logic [5:0]  ENTRY_END = 6'b111100;

  // The silent tail must fit inside a single beat.
  if (GAP_CYCLES >= BEAT_CYCLES) begin : g_gap_check
    $error("melody_sequencer: GAP_CYCLES must be smaller than BEAT_CYCLES");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t           state;
  logic [5:0]       ram [16];
  logic [CNT_W-1:0] beat_cnt;
  logic [1:0]       dur_cnt;

  logic [5:0]  cur_entry;
  logic [3:0]  cur_note;
  logic [1:0]  cur_beats;
  logic [3:0]  next_idx;
  logic [5:0]  next_entry;
  logic        beat_last;
  logic        note_expire;
  logic        next_is_end;
  logic        tail;
  logic [21:0] note_pitch;
  logic        note_tone;

  // Note number to half-period count; rests and END give zero.
  function automatic logic [21:0] decode_pitch(input logic [3:0] note);
    case (note)
      4'd1:    decode_pitch = 22'd191109;
      4'd2:    decode_pitch = 22'd170264;
      4'd3:    decode_pitch = 22'd151684;
      4'd4:    decode_pitch = 22'd143171;
      4'd5:    decode_pitch = 22'd127550;
      4'd6:    decode_pitch = 22'd113635;
      4'd7:    decode_pitch = 22'd101238;
      4'd8:    decode_pitch = 22'd95556;
      default: decode_pitch = 22'd0;
    endcase
  endfunction

  // Current entry decode, expiry detection and end-of-song lookahead.
  always_comb begin
    cur_entry   = ram[note_idx];
    cur_note    = cur_entry[5:2];
    cur_beats   = cur_entry[1:0];
    next_idx    = note_idx + 4'd1;
    next_entry  = ram[next_idx];
    beat_last   = (beat_cnt == CNT_W'(BEAT_CYCLES - 1));
    note_expire = beat_last && (dur_cnt == cur_beats);
    // Index 15 wrapping to 0 counts as reaching the end of the song.
    next_is_end = (next_idx == 4'd0) || (next_entry[5:2] == NOTE_END);
    note_pitch  = decode_pitch(cur_note);
    note_tone   = (cur_note >= 4'd1) && (cur_note <= 4'd8);
`ifdef NOTE_GAP_EN
    tail        = (dur_cnt == cur_beats) &&
                  (beat_cnt >= CNT_W'(BEAT_CYCLES - GAP_CYCLES));
`else
    tail        = 1'b0;
`endif
  end

  // Sequencer FSM, counters, song RAM and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      note_idx  <= 4'd0;
      beat_cnt  <= '0;
      dur_cnt   <= 2'd0;
      pitch     <= 22'd0;
      music     <= 1'b0;
      gen_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        ram[i] <= ENTRY_END;
      end
    end else begin
      done <= 1'b0;

      // Tone outputs follow the current state and entry one cycle later.
      case (state)
        PLAY: begin
          pitch <= note_pitch;
          music <= note_tone && !tail;
        end
        PAUSE: begin
          music <= 1'b0;
        end
        default: begin
          pitch <= 22'd0;
          music <= 1'b0;
        end
      endcase

      if (wr_en && (state == IDLE)) begin
        ram[wr_addr] <= wr_data;
      end

      case (state)
        IDLE: begin
          if (!stop && !pause && play) begin
            state     <= PLAY;
            note_idx  <= 4'd0;
            beat_cnt  <= '0;
            dur_cnt   <= 2'd0;
            busy      <= 1'b1;
            gen_start <= 1'b1;
          end
        end

        PLAY: begin
          if (stop) begin
            state     <= IDLE;
            note_idx  <= 4'd0;
            beat_cnt  <= '0;
            dur_cnt   <= 2'd0;
            busy      <= 1'b0;
            gen_start <= 1'b0;
          end else if (pause) begin
            state <= PAUSE;
          end else if (cur_note == NOTE_END) begin
            // Only reachable at entry 0: an empty song ends at once.
            state     <= IDLE;
            note_idx  <= 4'd0;
            beat_cnt  <= '0;
            dur_cnt   <= 2'd0;
            busy      <= 1'b0;
            gen_start <= 1'b0;
            done      <= 1'b1;
          end else if (note_expire) begin
            beat_cnt <= '0;
            dur_cnt  <= 2'd0;
            if (!next_is_end) begin
              note_idx <= next_idx;
            end else if (loop) begin
              // Entry 0 already played, so it is a real note: restart directly.
              note_idx <= 4'd0;
            end else begin
              state     <= IDLE;
              note_idx  <= 4'd0;
              busy      <= 1'b0;
              gen_start <= 1'b0;
              done      <= 1'b1;
            end
          end else if (beat_last) begin
            beat_cnt <= '0;
            dur_cnt  <= dur_cnt + 2'd1;
          end else begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end

        PAUSE: begin
          if (stop) begin
            state     <= IDLE;
            note_idx  <= 4'd0;
            beat_cnt  <= '0;
            dur_cnt   <= 2'd0;
            busy      <= 1'b0;
            gen_start <= 1'b0;
          end else if (play && !pause) begin
            state <= PLAY;
          end
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          gen_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Testbench for melody_sequencer with BEAT_CYCLES=4, GAP_CYCLES=1.
// Expected per-cycle outputs are queued as stimulus is applied and checked
// at the falling edge after each rising edge.
module tb_melody_sequencer;

  localparam int unsigned BEAT = 4;
  localparam int unsigned GAP  = 1;
`ifdef NOTE_GAP_EN
  localparam logic TAIL_M = 1'b0;
`else
  localparam logic TAIL_M = 1'b1;
`endif

  localparam logic [21:0] P_C4 = 22'd191109;
  localparam logic [21:0] P_E4 = 22'd151684;
  localparam logic [21:0] P_G4 = 22'd127550;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        play = 1'b0;
  logic        pause = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = 4'd0;
  logic [5:0]  wr_data = 6'd0;
  logic [21:0] pitch;
  logic        music;
  logic        gen_start;
  logic [3:0]  note_idx;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [21:0] pitch;
    logic        music;
    logic        done;
    logic        busy;
    bit          chk_pm;
  } exp_t;

  exp_t sb[$];

  melody_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .play(play), .pause(pause), .stop(stop),
    .loop(loop), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pitch(pitch), .music(music), .gen_start(gen_start),
    .note_idx(note_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [21:0] p, input logic m, input logic d,
                      input logic b, input bit c);
    exp_t e;
    e.pitch = p; e.music = m; e.done = d; e.busy = b; e.chk_pm = c;
    sb.push_back(e);
  endtask

  // Advance n cycles, comparing each cycle against the next queued entry.
  task automatic run(input int n);
    exp_t e;
    repeat (n) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $error("FAIL sb_underflow observed=0 expected=1");
      end else begin
        e = sb.pop_front();
        if (e.chk_pm) begin
          check("pitch", 32'(pitch), 32'(e.pitch));
          check("music", 32'(music), 32'(e.music));
        end
        check("done", 32'(done), 32'(e.done));
        check("busy", 32'(busy), 32'(e.busy));
        check("gen_start", 32'(gen_start), 32'(e.busy));
      end
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [5:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    push(22'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    run(1);
    wr_en = 1'b0;
  endtask

  task automatic start_play();
    play = 1'b1;
    push(22'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    run(1);
    play = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_pitch", 32'(pitch), 32'd0);
    check("rst_music", 32'(music), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_gen_start", 32'(gen_start), 32'd0);
    check("rst_idx", 32'(note_idx), 32'd0);
    rst = 1'b0;

    // Empty RAM: one cycle in PLAY, then done
    start_play();
    push(22'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    push(22'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    run(2);

    // Two-note song, no loop
    wr(4'd0, {4'd1, 2'd0});
    wr(4'd1, {4'd5, 2'd1});
    loop = 1'b0;
    start_play();
    for (int i = 0; i < 3; i++) push(P_C4, 1'b1, 1'b0, 1'b1, 1'b1);
    push(P_C4, TAIL_M, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) push(P_G4, 1'b1, 1'b0, 1'b1, 1'b1);
    push(P_G4, TAIL_M, 1'b1, 1'b0, 1'b1);
    push(22'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    run(13);
    check("end_idx", 32'(note_idx), 32'd0);

    // Loop back to entry 0; a write during PLAY must be ignored
    loop = 1'b1;
    start_play();
    for (int i = 0; i < 2; i++) push(P_C4, 1'b1, 1'b0, 1'b1, 1'b1);
    run(2);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 6'b111100;
    push(P_C4, 1'b1, 1'b0, 1'b1, 1'b1);
    run(1);
    wr_en = 1'b0;
    push(P_C4, TAIL_M, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) push(P_G4, 1'b1, 1'b0, 1'b1, 1'b1);
    push(P_G4, TAIL_M, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) push(P_C4, 1'b1, 1'b0, 1'b1, 1'b1);
    run(12);
    check("loop_idx", 32'(note_idx), 32'd0);
    // stop and play together mid-song
    stop = 1'b1; play = 1'b1;
    push(22'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    run(1);
    check("stop_idx", 32'(note_idx), 32'd0);
    stop = 1'b0; play = 1'b0; loop = 1'b0;
    push(22'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    run(1);

    // Pause in entry 0 for 10 cycles, then resume
    start_play();
    for (int i = 0; i < 2; i++) push(P_C4, 1'b1, 1'b0, 1'b1, 1'b1);
    run(2);
    pause = 1'b1;
    push(P_C4, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) push(P_C4, 1'b0, 1'b0, 1'b1, 1'b1);
    run(10);
    pause = 1'b0; play = 1'b1;
    push(P_C4, 1'b0, 1'b0, 1'b1, 1'b1);
    run(1);
    play = 1'b0;
    push(P_C4, 1'b1, 1'b0, 1'b1, 1'b1);
    run(1);
    check("resume_idx0", 32'(note_idx), 32'd0);
    push(P_C4, TAIL_M, 1'b0, 1'b1, 1'b1);
    run(1);
    check("resume_idx1", 32'(note_idx), 32'd1);
    stop = 1'b1;
    push(P_G4, 1'b1, 1'b0, 1'b0, 1'b1);
    run(1);
    stop = 1'b0;
    push(22'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    run(1);

    // Single one-beat note (gap behaviour depends on NOTE_GAP_EN)
    wr(4'd0, {4'd3, 2'd0});
    wr(4'd1, 6'b111100);
    start_play();
    for (int i = 0; i < 3; i++) push(P_E4, 1'b1, 1'b0, 1'b1, 1'b1);
    push(P_E4, TAIL_M, 1'b1, 1'b0, 1'b1);
    push(22'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    run(5);

    // Reset mid-playback aborts at once and reloads the RAM with END
    start_play();
    for (int i = 0; i < 2; i++) push(P_E4, 1'b1, 1'b0, 1'b1, 1'b1);
    run(2);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_pitch", 32'(pitch), 32'd0);
    check("arst_music", 32'(music), 32'd0);
    check("arst_idx", 32'(note_idx), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    start_play();
    push(22'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    push(22'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    run(2);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
